// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if -- handshake and data bundle for muldiv_sequencer.
//   start, op, a, b, flush : requester -> sequencer
//   busy, done, lo, hi, dz : sequencer -> requester
// master: requester side; slave: sequencer side.
interface muldiv_sequencer_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        dz;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, lo, hi, dz
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, lo, hi, dz
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// adder_32bits -- 32-bit ripple-carry adder.
//   A, B : operands
//   Cin  : 0 -> S = A + B, 1 -> S = A + ~B + 1 (subtract)
//   S, C : sum and carry out
module adder_32bits (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        C
);
  logic [31:0] bx;
  logic [32:0] cy;

  always_comb begin
    bx    = Cin ? ~B : B;
    cy    = '0;
    cy[0] = Cin;
    S     = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      S[i]    = A[i] ^ bx[i] ^ cy[i];
      cy[i+1] = (A[i] & bx[i]) | (cy[i] & (A[i] ^ bx[i]));
    end
    C = cy[32];
  end
endmodule

// muldiv_sequencer -- 32-bit unsigned multiply / divide, one bit per cycle,
// built around a single shared adder_32bits.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of muldiv_sequencer_if
//           start/op/a/b sampled when accepted in IDLE, flush aborts RUN,
//           busy high in RUN, done one-cycle pulse, lo/hi/dz held results.
module muldiv_sequencer (
  input  logic                  clk,
  input  logic                  rst_n,
  muldiv_sequencer_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        op_q;
  logic [31:0] opnd_q;   // multiplicand or divisor
  logic [31:0] acc_q;    // product high half or remainder
  logic [31:0] sh_q;     // multiplier/product low half, or dividend/quotient
  logic        busy_q;
  logic        done_q;
  logic [31:0] lo_q;
  logic [31:0] hi_q;
  logic        dz_q;

  logic [31:0] acc_d;
  logic [31:0] sh_d;
  logic [31:0] rem_sh;
  logic [31:0] add_a;
  logic [31:0] add_s;
  logic        add_c;
  logic        qbit;

  adder_32bits u_add (
    .A   (add_a),
    .B   (opnd_q),
    .Cin (op_q),
    .S   (add_s),
    .C   (add_c)
  );

  always_comb begin
    rem_sh = {acc_q[30:0], sh_q[31]};
    add_a  = op_q ? rem_sh : acc_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
    qbit   = 1'b0;
    if (!op_q) begin
      // {carry, acc, multiplier} >> 1; carry is zero when nothing was added
      if (sh_q[0]) begin
        acc_d = {add_c, add_s[31:1]};
        sh_d  = {add_s[0], sh_q[31:1]};
      end else begin
        acc_d = {1'b0, acc_q[31:1]};
        sh_d  = {acc_q[0], sh_q[31:1]};
      end
    end else begin
      // The bit shifted out of rem acts as the 33rd remainder bit, so a set
      // bit means the shifted remainder already exceeds any 32-bit divisor.
      qbit  = add_c | acc_q[31];
      acc_d = qbit ? add_s : rem_sh;
      sh_d  = {sh_q[30:0], qbit};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= bus.op;
            opnd_q  <= bus.b;
            sh_q    <= bus.a;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (bus.flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              lo_q    <= sh_d;
              hi_q    <= acc_d;
              dz_q    <= op_q & (opnd_q == '0);
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.lo   = lo_q;
  assign bus.hi   = hi_q;
  assign bus.dz   = dz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer -- directed vectors and multi-cycle corner sequences
// for muldiv_sequencer.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus();

  muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        op;
    logic        fl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  vec_t vecs[13];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a request on a negedge; returns right after the accepting posedge,
  // then scrambles the operand inputs to prove they were latched.
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y, input logic fl);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.flush = fl;
    @(posedge clk);
    #1;
    bus.a  = 32'hA5A5_A5A5;
    bus.b  = '0;
    bus.op = ~o;
  endtask

  // Counts negedges after the accepting edge until done (bounded).
  task automatic wait_done(output int lat, output logic busy1, output logic ovl);
    lat   = 0;
    busy1 = 1'b0;
    ovl   = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      if (lat == 1) busy1 = bus.busy;
      if (bus.done && bus.busy) ovl = 1'b1;
      if (bus.done || lat >= 100) break;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   lat;
    logic busy1, ovl;
    issue(v.op, v.a, v.b, v.fl);
    wait_done(lat, busy1, ovl);
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_busy_after_accept"}, {31'd0, busy1}, 32'd1);
    chk({tag, "_done_with_busy"}, {31'd0, ovl}, 32'd0);
    chk({tag, "_lo"}, bus.lo, v.lo);
    chk({tag, "_hi"}, bus.hi, v.hi);
    chk({tag, "_dz"}, {31'd0, bus.dz}, {31'd0, v.dz});
    @(negedge clk);
    chk({tag, "_done_single"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_lo_hold"}, bus.lo, v.lo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, first, second, n;
    logic busy1, ovl, seen;

    vecs[0]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'd3,         32'd5,         32'd15,        32'd0,         1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h1234_5678, 32'h10,        32'h2345_6780, 32'h1,         1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0,         32'h1,         1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 32'h1,         1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'd5,         32'd10,        32'd0,         32'd5,         1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'hF,         1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'd1000000,   32'd1000,      32'd1000,      32'd0,         1'b0};

    // Reset with start held: nothing may be accepted, outputs stay zero.
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd7;
    bus.b     = 32'd6;
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_dz", {31'd0, bus.dz}, 32'd0);
    // First edge with rst_n=1 accepts the held start.
    rst_n = 1'b1;
    @(posedge clk);
    wait_done(lat, busy1, ovl);
    chk("first_latency", 32'(lat), 32'd33);
    chk("first_busy", {31'd0, busy1}, 32'd1);
    chk("first_lo", bus.lo, 32'd42);
    chk("first_hi", bus.hi, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // start held through RUN and DONE: one accept per 34 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    @(posedge clk);
    first  = -1;
    second = -1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (bus.done) begin
        if (first < 0) first = k;
        else begin
          second = k;
          break;
        end
      end
    end
    bus.start = 1'b0;
    chk("hold_first_done", 32'(first), 32'd33);
    chk("hold_done_spacing", 32'(second - first), 32'd34);
    chk("hold_lo", bus.lo, 32'd15);
    @(negedge clk);

    // Flush at iteration 10: results of the previous op are retained.
    run_vec(vecs[8], "pre_flush");
    issue(1'b0, 32'd3, 32'd5, 1'b0);
    repeat (11) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_done", {31'd0, bus.done}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("flush_no_done", {31'd0, seen}, 32'd0);
    chk("flush_lo_kept", bus.lo, 32'hFFFF_FFFF);
    chk("flush_hi_kept", bus.hi, 32'h1234_5678);
    chk("flush_dz_kept", {31'd0, bus.dz}, 32'd1);
    run_vec(vecs[1], "post_flush");

    // Reset for one cycle at iteration 20.
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    n = 0;
    repeat (21) begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mrst_done", {31'd0, bus.done}, 32'd0);
    chk("mrst_lo", bus.lo, 32'd0);
    chk("mrst_hi", bus.hi, 32'd0);
    chk("mrst_dz", {31'd0, bus.dz}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("mrst_quiet", {31'd0, seen}, 32'd0);
    run_vec(vecs[6], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
